// File: rtl/fb_bus_pkg.sv
// ----------------------------------------------------------------------------
// fb_bus_pkg
//   Shared definitions for the frame-buffer bus: memory-access FSM states,
//   the "no byte lanes" select code, default data/address widths, and a helper
//   that sizes wait-state counters.
// ----------------------------------------------------------------------------
package fb_bus_pkg;

    localparam int unsigned FB_COLORW = 16;
    localparam int unsigned FB_ADDRW  = 18;

    // Active-low byte-lane select with neither lane enabled.
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        ACK
    } fb_mem_state_t;

    // Counter width able to hold wait_cycles; never narrower than one bit.
    function automatic int unsigned fb_cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/fb_wait_cnt.sv
// ----------------------------------------------------------------------------
// fb_wait_cnt
//   Loadable down-counter used to time SRAM strobes.
//   Ports:
//     clk_i       clock (posedge)
//     rst_i       asynchronous active-high reset, clears the count
//     load_i      load load_val_i (has priority over en_i)
//     load_val_i  value to load
//     en_i        decrement by one
//     zero_o      count is zero
// ----------------------------------------------------------------------------
module fb_wait_cnt #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fb_sram_responder.sv
// ----------------------------------------------------------------------------
// fb_sram_responder
//   Bus responder for the fill/blit initiators. Each accepted strobe performs
//   one access on an external 16-bit async SRAM (SETUP, ACCESS held for
//   WAIT_CYCLES+1 cycles, HOLD) and then returns a one-cycle ack. All outputs
//   are registered; they are computed from the next state.
//
//   Build option FB_SRAM_READ_EN: when defined, reads run a full SRAM read
//   cycle and return the captured word on dat_o. When undefined, reads spend a
//   single quiet cycle in SETUP (no pin activity) and are acked with dat_o=0.
//
//   Ports:
//     clk_i, rst_i               clock, asynchronous active-high reset
//     cyc_i, stb_i, we_i         bus cycle, single-cycle strobe, write enable
//     adr_i, dat_i, sel_i        word address, write data, active-low lanes
//     ack_o, dat_o               completion pulse, read data (valid with ack)
//     busy_o, err_o              not idle, sticky "strobe while busy"
//     sram_adr_o, sram_dq_o      SRAM address / write data
//     sram_dq_i, sram_dq_oe_o    SRAM read data / pad output enable
//     sram_ce_n_o .. sram_lb_n_o active-low SRAM controls
// ----------------------------------------------------------------------------
module fb_sram_responder
    import fb_bus_pkg::*;
#(
    parameter int unsigned COLORW      = FB_COLORW,
    parameter int unsigned ADDRW       = FB_ADDRW,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDRW-1:0]  adr_i,
    input  logic [COLORW-1:0] dat_i,
    input  logic [1:0]        sel_i,
    output logic              ack_o,
    output logic [COLORW-1:0] dat_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [ADDRW-1:0]  sram_adr_o,
    output logic [COLORW-1:0] sram_dq_o,
    input  logic [COLORW-1:0] sram_dq_i,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    localparam int unsigned CNTW = fb_cnt_width(WAIT_CYCLES);

    fb_mem_state_t state_q, state_d;

    logic              req_we_q, req_we_d;
    logic [ADDRW-1:0]  req_adr_q, req_adr_d;
    logic [COLORW-1:0] req_dat_q, req_dat_d;
    logic [1:0]        req_sel_q, req_sel_d;
    logic              cyc_lost_q, cyc_lost_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic [COLORW-1:0] dat_q, dat_d;
    logic [ADDRW-1:0]  adr_q, adr_d;
    logic [COLORW-1:0] dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;

    logic accept;
    logic mem_op_q, mem_op_d;
    logic cnt_load, cnt_en, cnt_zero;

    fb_wait_cnt #(
        .WIDTH (CNTW)
    ) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (CNTW'(WAIT_CYCLES)),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // Whether a request touches the SRAM pins at all.
`ifdef FB_SRAM_READ_EN
    assign mem_op_q = 1'b1;
    assign mem_op_d = 1'b1;
`else
    assign mem_op_q = req_we_q;
    assign mem_op_d = req_we_d;

    logic unused_dq;
    assign unused_dq = ^sram_dq_i;
`endif

    // A new request is taken in IDLE or on the edge that ends ACK.
    assign accept = stb_i & cyc_i & ((state_q == IDLE) || (state_q == ACK));

    assign cnt_load = (state_q == SETUP) && mem_op_q;
    assign cnt_en   = (state_q == ACCESS) && !cnt_zero;

    // Next state, request latch, status
    always_comb begin
        state_d    = state_q;
        req_we_d   = req_we_q;
        req_adr_d  = req_adr_q;
        req_dat_d  = req_dat_q;
        req_sel_d  = req_sel_q;
        cyc_lost_d = cyc_lost_q;
        err_d      = err_q;
        dat_d      = dat_q;

        if (accept) begin
            req_we_d  = we_i;
            req_adr_d = adr_i;
            req_dat_d = dat_i;
            req_sel_d = sel_i;
        end

        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = mem_op_q ? ACCESS : ACK;
            ACCESS:  if (cnt_zero) state_d = HOLD;
            HOLD:    state_d = ACK;
            ACK:     state_d = accept ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase

        if (stb_i && ((state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD))) begin
            err_d = 1'b1;
        end

        // Once cyc_i drops during an access the ack for it is withheld.
        if (accept) begin
            cyc_lost_d = 1'b0;
        end else if ((state_q != IDLE) && !cyc_i) begin
            cyc_lost_d = 1'b1;
        end

        if (accept) begin
            dat_d = '0;
        end
`ifdef FB_SRAM_READ_EN
        else if ((state_q == ACCESS) && cnt_zero && !req_we_q) begin
            dat_d = sram_dq_i;
        end
`endif

        ack_d = (state_d == ACK) && cyc_i && !cyc_lost_q;
    end

    // Registered pin values derived from the state being entered
    always_comb begin
        adr_d   = adr_q;
        dq_d    = dq_q;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;

        if (((state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD)) && mem_op_d) begin
            ce_n_d = 1'b0;
            adr_d  = req_adr_d;
            ub_n_d = req_sel_d[1];
            lb_n_d = req_sel_d[0];
            if (req_we_d) begin
                dq_d    = req_dat_d;
                dq_oe_d = 1'b1;
            end
            if (state_d == ACCESS) begin
                we_n_d = !req_we_d;
                oe_n_d = req_we_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_we_q   <= 1'b0;
            req_adr_q  <= '0;
            req_dat_q  <= '0;
            req_sel_q  <= SEL_NONE;
            cyc_lost_q <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            adr_q      <= '0;
            dq_q       <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_we_q   <= req_we_d;
            req_adr_q  <= req_adr_d;
            req_dat_q  <= req_dat_d;
            req_sel_q  <= req_sel_d;
            cyc_lost_q <= cyc_lost_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            adr_q      <= adr_d;
            dq_q       <= dq_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
        end
    end

    assign ack_o        = ack_q;
    assign dat_o        = dat_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign sram_adr_o   = adr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_ub_n_o  = ub_n_q;
    assign sram_lb_n_o  = lb_n_q;

endmodule

// File: tb/tb_fb_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_fb_sram_responder
//   Self-checking bench for fb_sram_responder with WAIT_CYCLES=2 and a small
//   behavioural SRAM. Expectations depend on FB_SRAM_READ_EN for the read case.
// ----------------------------------------------------------------------------
module tb_fb_sram_responder;

    localparam int unsigned W = 2;

    logic        clk, rst;
    logic        cyc, stb, we;
    logic [17:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        ack_o, busy_o, err_o;
    logic [15:0] dat_o;
    logic [17:0] sram_adr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        dq_oe, ce_n, we_n, oe_n, ub_n, lb_n;

    fb_sram_responder #(
        .COLORW      (16),
        .ADDRW       (18),
        .WAIT_CYCLES (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cyc_i        (cyc),
        .stb_i        (stb),
        .we_i         (we),
        .adr_i        (adr),
        .dat_i        (dat),
        .sel_i        (sel),
        .ack_o        (ack_o),
        .dat_o        (dat_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .sram_adr_o   (sram_adr),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_i    (sram_dq_i),
        .sram_dq_oe_o (dq_oe),
        .sram_ce_n_o  (ce_n),
        .sram_we_n_o  (we_n),
        .sram_oe_n_o  (oe_n),
        .sram_ub_n_o  (ub_n),
        .sram_lb_n_o  (lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM, 1K words aliased on adr[9:0]
    logic [15:0] mem [0:1023];
    int we_low, oe_low, ack_cnt;
    logic ub_low, lb_low, dq_bad;

    always @(sram_adr, oe_n) begin
        sram_dq_i = (!oe_n) ? mem[sram_adr[9:0]] : 16'h0000;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (ack_o) ack_cnt++;
            if (!ub_n) ub_low = 1'b1;
            if (!lb_n) lb_low = 1'b1;
            if (!we_n && !dq_oe) dq_bad = 1'b1;
            if (!ce_n && !we_n) begin
                if (!ub_n) mem[sram_adr[9:0]][15:8] = sram_dq_o[15:8];
                if (!lb_n) mem[sram_adr[9:0]][7:0]  = sram_dq_o[7:0];
            end
        end
    end

    int n_cmp, n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        we_low  = 0;
        oe_low  = 0;
        ack_cnt = 0;
        ub_low  = 1'b0;
        lb_low  = 1'b0;
        dq_bad  = 1'b0;
    endtask

    task automatic drive_req(input logic w, input logic [17:0] a, input logic [15:0] d,
                             input logic [1:0] s);
        stb = 1'b1;
        we  = w;
        adr = a;
        dat = d;
        sel = s;
    endtask

    // Issue one request and report the edge index after which ack_o was seen
    // (the accepting edge is edge 0). -1 means no ack within the budget.
    task automatic run_req(input logic w, input logic [17:0] a, input logic [15:0] d,
                           input logic [1:0] s, output int ack_e,
                           output logic [15:0] rd);
        ack_e = -1;
        rd    = 16'hxxxx;
        clr_mon();
        drive_req(w, a, d, s);
        for (int e = 0; e < 40; e++) begin
            step();
            if (e == 0) stb = 1'b0;
            if (ack_o) begin
                ack_e = e;
                rd    = dat_o;
                break;
            end
        end
        step();
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [17:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        int          ack_e;
        int          we_low;
        int          oe_low;
        logic [15:0] mem;
        logic [15:0] rd;
        logic        ub_low;
        logic        lb_low;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          ack_e;
        logic [15:0] rd;
        time         t_ack [4];

        vecs[0] = '{"wr_full", 1'b1, 18'h01234, 16'hF800, 2'b00, W+3, W+1, 0, 16'hF800,
                    16'h0000, 1'b1, 1'b1};
        vecs[1] = '{"wr_upper", 1'b1, 18'h00100, 16'h1234, 2'b01, W+3, W+1, 0, 16'h1200,
                    16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"wr_lower", 1'b1, 18'h00101, 16'hABCD, 2'b10, W+3, W+1, 0, 16'h00CD,
                    16'h0000, 1'b0, 1'b1};
        vecs[3] = '{"wr_nolane", 1'b1, 18'h00102, 16'h5555, 2'b11, W+3, W+1, 0, 16'h0000,
                    16'h0000, 1'b0, 1'b0};
`ifdef FB_SRAM_READ_EN
        vecs[4] = '{"rd", 1'b0, 18'h00010, 16'h0000, 2'b00, W+3, 0, W+1, 16'hABCD,
                    16'hABCD, 1'b1, 1'b1};
`else
        vecs[4] = '{"rd", 1'b0, 18'h00010, 16'h0000, 2'b00, 1, 0, 0, 16'hABCD,
                    16'h0000, 1'b0, 1'b0};
`endif

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hABCD;
        clr_mon();

        rst = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        adr = '0;
        dat = '0;
        sel = 2'b11;
        step();
        step();

        // Reset state
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_dat", 32'(dat_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_adr", 32'(sram_adr), 0);
        chk("rst_dq", 32'(sram_dq_o), 0);
        chk("rst_dq_oe", 32'(dq_oe), 0);
        chk("rst_ctl_n", 32'({ce_n, we_n, oe_n, ub_n, lb_n}), 32'h1F);
        rst = 1'b0;
        step();

        // stb without cyc is ignored
        stb = 1'b1;
        we  = 1'b1;
        step();
        stb = 1'b0;
        chk("nocyc_busy", 32'(busy_o), 0);
        chk("nocyc_err", 32'(err_o), 0);
        cyc = 1'b1;
        step();

        // Table-driven single accesses
        foreach (vecs[i]) begin
            run_req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, ack_e, rd);
            chk({vecs[i].name, "_ack_edge"}, 32'(ack_e), 32'(vecs[i].ack_e));
            chk({vecs[i].name, "_we_low"}, 32'(we_low), 32'(vecs[i].we_low));
            chk({vecs[i].name, "_oe_low"}, 32'(oe_low), 32'(vecs[i].oe_low));
            chk({vecs[i].name, "_mem"}, 32'(mem[vecs[i].adr[9:0]]), 32'(vecs[i].mem));
            chk({vecs[i].name, "_dat_o"}, 32'(rd), 32'(vecs[i].rd));
            chk({vecs[i].name, "_ub_low"}, 32'(ub_low), 32'(vecs[i].ub_low));
            chk({vecs[i].name, "_lb_low"}, 32'(lb_low), 32'(vecs[i].lb_low));
            chk({vecs[i].name, "_dq_oe"}, 32'(dq_bad), 0);
            chk({vecs[i].name, "_ack_cnt"}, 32'(ack_cnt), 1);
            chk({vecs[i].name, "_idle"}, 32'(busy_o), 0);
        end
        chk("table_err", 32'(err_o), 0);

        // Back-to-back writes: next strobe presented during the ACK cycle
        clr_mon();
        for (int i = 0; i < 4; i++) t_ack[i] = 0;
        drive_req(1'b1, 18'h0, 16'h07E0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            int found;
            found = 0;
            for (int e = 0; e < 40 && found == 0; e++) begin
                step();
                if (e == 0) stb = 1'b0;
                if (ack_o) found = 1;
            end
            if (found == 0) begin
                chk("b2b_ack_timeout", 32'(i), 32'hFFFF_FFFF);
                break;
            end
            t_ack[i] = $time;
            if (i < 3) drive_req(1'b1, 18'(i + 1), 16'h07E0, 2'b00);
        end
        step();
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(t_ack[i] - t_ack[i-1]), 32'((W+4)*10));
        for (int i = 0; i < 4; i++) chk("b2b_mem", 32'(mem[i]), 32'h07E0);
        chk("b2b_acks", 32'(ack_cnt), 4);
        chk("b2b_we_low", 32'(we_low), 4*(W+1));
        chk("b2b_err", 32'(err_o), 0);

        // Strobe during ACCESS is dropped and flags err_o
        clr_mon();
        drive_req(1'b1, 18'h00200, 16'h1111, 2'b00);
        step();
        stb = 1'b0;
        step();
        drive_req(1'b1, 18'h00201, 16'h2222, 2'b00);
        step();
        stb = 1'b0;
        for (int e = 0; e < 12; e++) step();
        chk("err_set", 32'(err_o), 1);
        chk("err_we_low", 32'(we_low), W+1);
        chk("err_acks", 32'(ack_cnt), 1);
        chk("err_mem_first", 32'(mem[10'h200]), 32'h1111);
        chk("err_mem_dropped", 32'(mem[10'h201]), 0);
        chk("err_idle", 32'(busy_o), 0);
        run_req(1'b1, 18'h00202, 16'h3030, 2'b00, ack_e, rd);
        chk("err_sticky", 32'(err_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared", 32'(err_o), 0);
        step();

        // cyc_i drop during ACCESS: full strobe, no ack
        clr_mon();
        drive_req(1'b1, 18'h00300, 16'h3333, 2'b00);
        step();
        stb = 1'b0;
        step();
        cyc = 1'b0;
        for (int e = 0; e < 12; e++) step();
        chk("drop_we_low", 32'(we_low), W+1);
        chk("drop_acks", 32'(ack_cnt), 0);
        chk("drop_idle", 32'(busy_o), 0);
        chk("drop_mem", 32'(mem[10'h300]), 32'h3333);
        cyc = 1'b1;
        step();

        // Asynchronous reset between edges in ACCESS
        drive_req(1'b1, 18'h00400, 16'h4444, 2'b00);
        step();
        stb = 1'b0;
        step();
        chk("arst_pre_we_n", 32'(we_n), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we_n", 32'(we_n), 1);
        chk("arst_ce_n", 32'(ce_n), 1);
        chk("arst_dq_oe", 32'(dq_oe), 0);
        chk("arst_busy", 32'(busy_o), 0);
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
